// File: rtl/hypot_pkg.sv
// hypot_pkg: shared width, state encoding and iteration counts for the leg solver
package hypot_pkg;
  localparam int W = 8;
  localparam int SQ_CYC = W;
  localparam int ROOT_CYC = W;
  typedef enum logic [2:0] {IDLE, SQ_R, SQ_A, SUB, ROOT, DONE} state_e;
endpackage

// File: rtl/shift_add_square.sv
// shift_add_square: iterative x*x via shift-add, one multiplier bit per cycle
module shift_add_square import hypot_pkg::*; #(
  parameter int W = hypot_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   x_in,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] sq
);
  localparam int CW = $clog2(W);
  logic [W-1:0] x_q, x_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, load, last;
  assign load = start && !busy_q;
  assign last = busy_q && cnt_q == CW'(SQ_CYC - 1);
  // bit 0 is folded into the load so the whole square takes exactly W edges
  always_comb begin
    x_d = load ? x_in : x_q;
    cnt_d = load ? CW'(1) : busy_q ? cnt_q + 1'b1 : cnt_q;
    acc_d = load ? (x_in[0] ? {{W{1'b0}}, x_in} : '0)
          : (busy_q && x_q[cnt_q]) ? acc_q + ({{W{1'b0}}, x_q} << cnt_q) : acc_q;
    busy_d = load || (busy_q && !last);
    done_d = last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q <= x_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sq = acc_q;
endmodule

// File: rtl/hypot_leg_solver.sv
// hypot_leg_solver: b = floor(sqrt(r*r - a*a)) with shared squarer and restoring root
module hypot_leg_solver import hypot_pkg::*; #(
  parameter int W = hypot_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] b_out,
  output logic         err
);
  localparam int CW = $clog2(W);
  localparam int DW = 2 * W;
  state_e state_q, state_d;
  logic [W-1:0] r_q, r_d, a_q, a_d, root_q, root_d, b_q, b_d, t;
  logic [DW-1:0] r2_q, r2_d, rem_q, rem_d, sqr_q, sqr_d, t2, sq_out;
  logic [CW-1:0] k_q, k_d;
  logic err_q, err_d, sq_start, sq_busy, sq_done, keep;
  assign sq_start = state_q == SQ_R && !sq_busy;
  shift_add_square #(.W(W)) u_sq (
    .clk(clk), .rst(rst), .start(sq_start), .x_in(sq_done ? a_q : r_q),
    .busy(sq_busy), .done(sq_done), .sq(sq_out)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? SQ_R : IDLE;
      SQ_R: state_d = sq_done ? SQ_A : SQ_R;
      SQ_A: state_d = sq_done ? SUB : SQ_A;
      SUB:  state_d = a_q > r_q ? DONE : ROOT;
      ROOT: state_d = k_q == '0 ? DONE : ROOT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE && state_q != DONE;
    done = state_q == DONE;
  end
  // trial square grows incrementally: (root + 2^k)^2 = root^2 + root*2^(k+1) + 2^(2k)
  assign t = root_q | (W'(1) << k_q);
  assign t2 = sqr_q + ({{W{1'b0}}, root_q} << ({1'b0, k_q} + 1'b1)) + (DW'(1) << {k_q, 1'b0});
  assign keep = t2 <= rem_q;
  always_comb begin
    r_d = r_q;
    a_d = a_q;
    r2_d = r2_q;
    rem_d = rem_q;
    sqr_d = sqr_q;
    root_d = root_q;
    k_d = k_q;
    b_d = b_q;
    err_d = err_q;
    if (state_q == IDLE && start) begin
      r_d = r_in;
      a_d = a_in;
      b_d = '0;
      err_d = 1'b0;
    end
    if (state_q == SQ_R && sq_done) r2_d = sq_out;
    if (state_q == SUB) begin
      err_d = a_q > r_q;
      rem_d = a_q > r_q ? '0 : r2_q - sq_out;
      root_d = '0;
      sqr_d = '0;
      k_d = CW'(ROOT_CYC - 1);
    end
    if (state_q == ROOT) begin
      root_d = keep ? t : root_q;
      sqr_d = keep ? t2 : sqr_q;
      k_d = k_q - 1'b1;
      b_d = k_q == '0 ? root_d : b_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      a_q <= '0;
      r2_q <= '0;
      rem_q <= '0;
      sqr_q <= '0;
      root_q <= '0;
      k_q <= '0;
      b_q <= '0;
      err_q <= 1'b0;
    end else begin
      r_q <= r_d;
      a_q <= a_d;
      r2_q <= r2_d;
      rem_q <= rem_d;
      sqr_q <= sqr_d;
      root_q <= root_d;
      k_q <= k_d;
      b_q <= b_d;
      err_q <= err_d;
    end
  end
  assign b_out = b_q;
  assign err = err_q;
endmodule
